pcm_frame_ctrl: RTL and testbench

PCM_FRAME_CTRL -- requirements
Module: pcm_frame_ctrl

---
 rtl/pcm_pkg.sv | 12 +
 rtl/pcm_fifo.sv | 65 ++++++
 rtl/pcm_frame_ctrl.sv | 107 ++++++++++
 tb/tb_pcm_frame_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// Shared constants for the PCM frame controller.
package pcm_pkg;

    localparam int unsigned SAMPLE_W            = 18;
    localparam int unsigned SLOT_BITS           = 32;
    localparam int unsigned FRAME_BITS          = 64;
    localparam int unsigned CAPTURE_IDX_DEFAULT = 19;

    localparam int unsigned CNT_W  = $clog2(FRAME_BITS);
    localparam int unsigned SLOT_W = $clog2(SLOT_BITS);

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous sample FIFO. Head entry comes straight from storage, so the read
// side never depends combinationally on the pop request. Full and empty are
// derived from the occupancy count; the pointers simply wrap.
module pcm_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_q];

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when a pop frees the head slot on the same edge.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (!do_push && do_pop) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pcm_frame_ctrl.sv
// PCM microphone frame controller: 64-bclk frame counter, word select, sample
// capture from the upstream deserializer, and a buffered sample output.
// Build option: define PCM_STEREO_EN to capture both slots; otherwise only the
// left slot is captured and sample_ch is tied low.
module pcm_frame_ctrl
    import pcm_pkg::*;
#(
    parameter int unsigned CAPTURE_IDX = CAPTURE_IDX_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                         bclk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [SAMPLE_W-1:0]          data,
    output logic                         ws,
    output logic [SAMPLE_W-1:0]          sample,
    output logic                         sample_ch,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]  level
);

`ifdef PCM_STEREO_EN
    localparam int unsigned ENTRY_W = SAMPLE_W + 1;
`else
    localparam int unsigned ENTRY_W = SAMPLE_W;
`endif

    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               ws_q;
    logic               ovf_q;
    logic               capture;
    logic               drop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full;
    logic               fifo_empty;

    // Next count and capture decode; disabling parks the counter at the
    // start of a fresh frame.
    always_comb begin
        cnt_d   = en ? cnt_q + CNT_W'(1) : '0;
        capture = en && (cnt_q[SLOT_W-1:0] == SLOT_W'(CAPTURE_IDX));
`ifndef PCM_STEREO_EN
        capture = capture && !cnt_q[CNT_W-1];
`endif
    end

    // Frame counter and word select; ws tracks the MSB of the count it is
    // registered alongside, so it stays aligned to cnt without extra delay.
    always_ff @(posedge bclk) begin
        if (reset) begin
            cnt_q <= '0;
            ws_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ws_q  <= cnt_d[CNT_W-1];
        end
    end

    // A full FIFO always has a head, so a ready consumer frees a slot.
    assign drop = capture && fifo_full && !sample_ready;

    // Sticky overflow; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge bclk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef PCM_STEREO_EN
    assign push_entry = {cnt_q[CNT_W-1], data};
    assign sample     = head_entry[SAMPLE_W-1:0];
    assign sample_ch  = head_entry[SAMPLE_W];
`else
    assign push_entry = data;
    assign sample     = head_entry;
    assign sample_ch  = 1'b0;
`endif

    pcm_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (bclk),
        .reset (reset),
        .push  (capture),
        .wdata (push_entry),
        .pop   (sample_ready),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign ws           = ws_q;
    assign sample_valid = !fifo_empty;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_pcm_frame_ctrl.sv
// Directed bench for pcm_frame_ctrl; adapts expectations to the PCM_STEREO_EN build.
module tb_pcm_frame_ctrl;

    localparam int unsigned CAP_IDX = 19;
    localparam int unsigned DEPTH   = 4;
`ifdef PCM_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    logic        bclk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [17:0] data = '0;
    logic        ws;
    logic [17:0] sample;
    logic        sample_ch;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic [2:0]  level;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] m_cnt = '0;
    logic last_cap = 1'b0;

    pcm_frame_ctrl #(
        .CAPTURE_IDX (CAP_IDX),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .bclk         (bclk),
        .reset        (reset),
        .en           (en),
        .data         (data),
        .ws           (ws),
        .sample       (sample),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .level        (level)
    );

    always #5 bclk = ~bclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic will_cap();
        return en && !reset && (m_cnt[4:0] == 5'(CAP_IDX)) && (STEREO || !m_cnt[5]);
    endfunction

    // One bclk edge; the bench's own counter model follows it.
    task automatic step();
        logic cap;
        cap = will_cap();
        @(posedge bclk);
        #1;
        if (reset || !en) m_cnt = '0;
        else m_cnt = m_cnt + 6'd1;
        last_cap = cap;
    endtask

    // Run until the next capture edge, presenting d; ready is rdy only on that edge.
    task automatic capture(input logic [17:0] d, input logic rdy);
        int guard;
        guard = 0;
        data = d;
        do begin
            sample_ready = will_cap() ? rdy : 1'b0;
            step();
            guard++;
        end while (!last_cap && guard < 200);
        sample_ready = 1'b0;
        if (!last_cap) begin
            vectors++;
            miscompares++;
            $display("FAIL capture_timeout: got no capture expected one within 200 cycles");
        end
    endtask

    initial begin
        int nsamp;
        int ph;
        logic exp_v;
        logic [17:0] exp_q [$];

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("rst_ws", 32'(ws), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_ch", 32'(sample_ch), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Word select timing and pass-through captures with a ready consumer
        en = 1'b1;
        sample_ready = 1'b1;
        nsamp = 0;
        for (int i = 1; i <= 200; i++) begin
            data = m_cnt[5] ? 18'h15555 : 18'h2AAAA;
            step();
            ph = i % 64;
            check("ws", 32'(ws), 32'(ph >= 32));
            exp_v = (ph == 20) || (STEREO && ph == 52);
            check("valid", 32'(sample_valid), 32'(exp_v));
            if (sample_valid) begin
                nsamp++;
                check("sample", 32'(sample), (ph >= 32) ? 32'h15555 : 32'h2AAAA);
                check("sample_ch", 32'(sample_ch), 32'(ph >= 32));
            end
        end
        check("nsamp", 32'(nsamp), STEREO ? 32'd6 : 32'd3);
        en = 1'b0;
        step();
        check("ws_disabled", 32'(ws), 32'd0);

        // Overflow: six captures into a depth-4 FIFO with no consumer
        reset = 1'b1;
        step();
        reset = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            capture(18'h100 + 18'(k), 1'b0);
            if (k <= 4) check("fill_level", 32'(level), 32'(k));
            if (k == 4) check("ovf_before", 32'(overflow), 32'd0);
            if (k >= 5) check("ovf_after", 32'(overflow), 32'd1);
        end
        check("ovf_level", 32'(level), 32'd4);
        en = 1'b0;
        sample_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_valid", 32'(sample_valid), 32'd1);
            check("drain_sample", 32'(sample), 32'h100 + 32'(k));
            step();
        end
        sample_ready = 1'b0;
        check("drained_valid", 32'(sample_valid), 32'd0);
        check("drained_level", 32'(level), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Clear coinciding with a drop keeps overflow set
        en = 1'b1;
        for (int k = 1; k <= 4; k++) capture(18'h200 + 18'(k), 1'b0);
        ovf_clr = 1'b1;
        capture(18'h2EE, 1'b0);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        en = 1'b0;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("full_level", 32'(level), 32'd4);

        // Full FIFO, capture coincident with a pop
        en = 1'b1;
        capture(18'h2FF, 1'b1);
        check("pushpop_level", 32'(level), 32'd4);
        check("pushpop_ovf", 32'(overflow), 32'd0);
        en = 1'b0;
        sample_ready = 1'b1;
        exp_q = '{18'h202, 18'h203, 18'h204, 18'h2FF};
        foreach (exp_q[j]) begin
            check("pushpop_drain", 32'(sample), 32'(exp_q[j]));
            step();
        end
        sample_ready = 1'b0;
        check("pushpop_empty", 32'(sample_valid), 32'd0);

        // Reset mid-frame with two buffered samples
        en = 1'b1;
        capture(18'h301, 1'b0);
        capture(18'h302, 1'b0);
        check("pre_rst_level", 32'(level), 32'd2);
        begin
            int guard;
            guard = 0;
            while (m_cnt != 6'd40 && guard < 200) begin
                step();
                guard++;
            end
            check("reached_cnt40", 32'(m_cnt), 32'd40);
        end
        check("cnt40_ws", 32'(ws), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_ws", 32'(ws), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_sample", 32'(sample), 32'd0);
        for (int i = 1; i <= 31; i++) step();
        check("restart_ws_lo", 32'(ws), 32'd0);
        step();
        check("restart_ws_hi", 32'(ws), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
